subtractor_serial: RTL and testbench
====================================

// Module: subtractor_serial
// PURPOSE
//   Multi-cycle digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
//   Counterpart to the combinational ripple-carry adder; trades latency for area.
//   Sits in the arithmetic datapath behind a valid/ready handshake on both sides.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   DIGIT  4   bits processed per RUN cycle; WIDTH % DIGIT == 0 required (elaboration error otherwise)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a, b, bin valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      diff/bout/ovf valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      borrow-out: 1 iff unsigned a < b + bin
//   ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//   Clock/reset: single clock clk; reset asynchronous, active-low (rst_n).
//   Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, digit counter=0, borrow reg=0.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. in_valid&&in_ready at edge -> latch a, b; borrow reg<=bin; cnt<=0; -> RUN.
//   - RUN: each cycle {brw, d} = a[cnt*DIGIT +: DIGIT] - b[cnt*DIGIT +: DIGIT] - brw;
//     d written to diff[cnt*DIGIT +: DIGIT]; cnt++. On cycle cnt==WIDTH/DIGIT-1 -> DONE,
//     bout<=final brw, ovf computed from latched a/b MSBs and final diff MSB.
//   - DONE: out_valid=1; diff/bout/ovf stable. out_ready at edge -> IDLE, out_valid<=0.
//   Latency: accept edge to out_valid high = WIDTH/DIGIT + 1 edges (32/4 -> 9).
//   Throughput: one op per WIDTH/DIGIT + 2 cycles with out_ready tied high.
//   in_ready=0 in RUN and DONE; in_valid ignored there (no queueing, operands not re-sampled).
//   out_ready ignored outside DONE. Result held indefinitely under back-pressure.
//   Latched operands are internal; input changes after acceptance do not affect result.
//   diff wraps modulo 2^WIDTH; no saturation.
//   Leaving DONE and accepting new operands never occur on the same edge (in_ready low in DONE).
//   rst_n low mid-RUN or mid-DONE: immediate return to reset values, in-flight op discarded, no out_valid.
//   Outputs diff/bout/ovf retain last result after DONE->IDLE until next DONE overwrite.
// TESTING
//   1) a=0x0000_0005, b=0x0000_0003, bin=0 -> after 9 edges out_valid=1, diff=0x0000_0002, bout=0, ovf=0.
//   2) a=0, b=1, bin=0 -> diff=0xFFFF_FFFF, bout=1, ovf=0 (borrow ripples through all 8 digits).
//   3) a=0x8000_0000, b=1, bin=0 -> diff=0x7FFF_FFFF, bout=0, ovf=1; a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, bout=1, ovf=1.
//   4) a=0x1234_5678, b=0x1234_5678, bin=1 -> diff=0xFFFF_FFFF, bout=1; hold out_ready=0 10 cycles -> outputs stable, in_ready=0.
//   5) Assert in_valid with new operands during RUN -> ignored, result matches first op; back-to-back ops with out_ready=1 -> 10-cycle spacing.
//   6) rst_n low at RUN cycle 4 -> out_valid=0, in_ready=1 immediately; next op a=10,b=4 -> diff=6 with normal latency.
//   Plus random a/b/bin vs. reference model (a-b-bin), DIGIT in {1,4,8,32}.

Source files
------------

// File: rtl/subtractor_serial.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per cycle, LSB first.
// Valid/ready on both sides; one operation in flight at a time.
module subtractor_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
      $error("WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             brw;
   logic             a_msb;
   logic             b_msb;

   logic [DIGIT:0]   sub;
   logic [WIDTH-1:0] acc_nx;

   // Operands shift right each cycle; result digits enter acc from the top.
   always_comb begin
      sub = {1'b0, opa[DIGIT-1:0]} - {1'b0, opb[DIGIT-1:0]}
            - (DIGIT+1)'(brw);
      acc_nx = (acc >> DIGIT)
               | (WIDTH'(sub[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         ovf       <= 1'b0;
         opa       <= '0;
         opb       <= '0;
         acc       <= '0;
         cnt       <= '0;
         brw       <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa      <= a;
                  opb      <= b;
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
                  brw      <= bin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               opa <= opa >> DIGIT;
               opb <= opb >> DIGIT;
               acc <= acc_nx;
               brw <= sub[DIGIT];
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  diff      <= acc_nx;
                  bout      <= sub[DIGIT];
                  ovf       <= (a_msb != b_msb)
                               && (acc_nx[WIDTH-1] != a_msb);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial: directed table, handshake corners,
// and random operands against an arithmetic reference, several DIGITs.
module tb_subtractor_serial;

   logic        clk;
   logic        rst_n;
   logic        rst_x;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;

   int nvec = 0;
   int nmis = 0;
   logic [2:0] xdone = '0;

   subtractor_serial #(.WIDTH(32), .DIGIT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] got,
                                 logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Reference: plain 64-bit arithmetic on the unsigned/signed values.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, output logic [31:0] d,
                                 output logic bo, output logic ov);
      longint ux = x;
      longint uy = y;
      longint sx = $signed(x);
      longint sy = $signed(y);
      longint ci = c;
      longint r  = sx - sy - ci;
      d  = 32'(ux - uy - ci);
      bo = ux < uy + ci;
      ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                        input logic c, output int lat);
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      a = x;
      b = y;
      bin = c;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      bin = 1'($urandom);
      wait_valid(lat);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int lat;
      int n;
      logic ok;
      logic [31:0] ed;
      logic eb;
      logic eo;

      tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
      tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
      tbl[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      tbl[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[5] = '{32'h0000_000A, 32'h0000_0004, 1'b0, 32'h0000_0006, 1'b0, 1'b0};
      tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[8] = '{32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0};

      rst_n = 1'b0;
      rst_x = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      bin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_bout_ovf", 64'({bout, ovf}), 64'd0);
      rst_n = 1'b1;
      rst_x = 1'b1;

      foreach (tbl[i]) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
         check($sformatf("tbl%0d_lat", i), 64'(lat), 64'd9);
         check($sformatf("tbl%0d_diff", i), 64'(diff), 64'(tbl[i].d));
         check($sformatf("tbl%0d_bout", i), 64'(bout), 64'(tbl[i].bo));
         check($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].ov));
      end

      repeat (3) @(negedge clk);
      check("retain_valid", 64'(out_valid), 64'd0);
      check("retain_diff", 64'(diff), 64'h0000_000F);

      // Back-pressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      do_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat);
      check("hold_lat", 64'(lat), 64'd9);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         ok &= out_valid && !in_ready && bout && (diff == 32'hFFFF_FFFF);
      end
      check("hold_stable", 64'(ok), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("hold_release", 64'({out_valid, in_ready}), 64'b01);

      // New operands offered during RUN must be ignored.
      a = 32'h5;
      b = 32'h3;
      bin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      ok = 1'b1;
      repeat (7) begin
         @(negedge clk);
         a = $urandom;
         b = $urandom;
         bin = 1'($urandom);
         ok &= !in_ready;
      end
      in_valid = 1'b0;
      @(negedge clk);
      wait_valid(lat);
      check("busy_in_ready", 64'(ok), 64'd1);
      check("busy_diff", 64'(diff), 64'd2);
      @(negedge clk);

      // Back-to-back with in_valid held and out_ready high.
      a = 32'h100;
      b = 32'h1;
      bin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_valid(lat);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 40);
      in_valid = 1'b0;
      check("b2b_spacing", 64'(n), 64'd10);
      check("b2b_diff", 64'(diff), 64'hFF);
      @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      a = 32'h55;
      b = 32'h11;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready_valid", 64'({in_ready, out_valid}), 64'b10);
      check("midrst_diff", 64'(diff), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(32'd10, 32'd4, 1'b0, lat);
      check("postrst_lat", 64'(lat), 64'd9);
      check("postrst_diff", 64'(diff), 64'd6);

      for (int i = 0; i < 200; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic rc;
         ra = $urandom;
         rb = (i % 8 == 0) ? ra : $urandom;
         rc = 1'($urandom_range(0, 1));
         if (i % 16 == 1) ra[31] = ~rb[31];
         model(ra, rb, rc, ed, eb, eo);
         do_op(ra, rb, rc, lat);
         check("rnd_lat", 64'(lat), 64'd9);
         check("rnd_diff", 64'(diff), 64'(ed));
         check("rnd_bout", 64'(bout), 64'(eb));
         check("rnd_ovf", 64'(ovf), 64'(eo));
      end

      n = 0;
      while (xdone != 3'b111 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("other_digits_done", 64'(xdone), 64'b111);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   // Extra instances with DIGIT = 1, 8, 32 under random operands.
   for (genvar g = 0; g < 3; g++) begin : gx
      localparam int D = (g == 0) ? 1 : (g == 1) ? 8 : 32;
      logic        iv;
      logic        ir;
      logic [31:0] xa;
      logic [31:0] xb;
      logic        xc;
      logic        ov;
      logic        orr;
      logic [31:0] xd;
      logic        xbo;
      logic        xov;

      subtractor_serial #(.WIDTH(32), .DIGIT(D)) u_x (
         .clk(clk), .rst_n(rst_x),
         .in_valid(iv), .in_ready(ir),
         .a(xa), .b(xb), .bin(xc),
         .out_valid(ov), .out_ready(orr),
         .diff(xd), .bout(xbo), .ovf(xov)
      );

      initial begin
         int lat;
         logic [31:0] ed;
         logic eb;
         logic eo;
         iv = 1'b0;
         orr = 1'b1;
         xa = '0;
         xb = '0;
         xc = 1'b0;
         wait (rst_x);
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            xa = $urandom;
            xb = (i % 7 == 0) ? xa : $urandom;
            xc = 1'($urandom_range(0, 1));
            model(xa, xb, xc, ed, eb, eo);
            check($sformatf("d%0d_ready", D), 64'(ir), 64'd1);
            iv = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iv = 1'b0;
            xa = $urandom;
            lat = 1;
            while (!ov && lat < 100) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
            end
            check($sformatf("d%0d_lat", D), 64'(lat), 64'(32 / D + 1));
            check($sformatf("d%0d_diff", D), 64'(xd), 64'(ed));
            check($sformatf("d%0d_flags", D), 64'({xbo, xov}),
                  64'({eb, eo}));
         end
         xdone[g] = 1'b1;
      end
   end

endmodule
